opl_timer_bank: RTL and testbench
=================================

# opl_timer_bank

Parametrised bank of OPL-style up-counting interval timers. It is the next generation of the two-timer OPL3 status/IRQ logic. Each channel adds a configurable width, its own tick divider, auto-reload or one-shot mode, and per-channel flag clear. The block sits beside the register file: it decodes timer register writes, drives the status byte returned on status reads, and drives the active-low interrupt line to the host bus bridge.

## Interface
- NUM_TIMERS, 2: number of timer channels; legal range 1–6.
- TIMER_WIDTH, 8: counter and preload width; legal range 4–8.
- BASE_TICK_CYCLES, 4000: clk cycles per tick for channel 0; must be ≥ 2.
- TICK_RATIO_LOG2, 2: channel i ticks every BASE_TICK_CYCLES << (i*TICK_RATIO_LOG2) cycles.
- ADDR_WIDTH, 5: register address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- reg_wr_valid  in  1  one-cycle register write strobe.
- reg_wr_addr  in  ADDR_WIDTH  register address.
- reg_wr_data  in  8  register write data.
- status  out  8  bit 7 = irq, bits [NUM_TIMERS-1:0] = flags, other bits 0.
- running  out  NUM_TIMERS  per-channel run state.
- irq_n  out  1  registered, active-low interrupt.
- force_overflow  in  NUM_TIMERS  present only with OPL_TIMER_FORCE_OVF_EN.

## Operation
- Address map: 2i = PRELOAD[i]; 2i+1 = CTRL[i]; 2*NUM_TIMERS = GLOBAL. All other addresses are ignored.
- CTRL[i] bits:
  - bit0 start: stored in run[i].
  - bit1 mask: a masked channel never sets its flag.
  - bit2 one-shot.
  - bit3 clear flag[i]: self-clearing, never stored.
- GLOBAL bit7 clears all flags. Other GLOBAL bits are ignored.
- Channel states: IDLE (run=0) and RUN (run=1).
  - IDLE→RUN on a CTRL write with start=1 while IDLE: counter ← PRELOAD, prescaler ← 0.
  - A CTRL write with start=1 while in RUN does not restart the channel.
  - RUN→IDLE on a CTRL write with start=0: counter and prescaler hold their values, and no tick is produced.
- Tick: in RUN, the prescaler counts 0..TICK_i−1. At TICK_i−1 it wraps to 0 and the counter increments.
- Overflow: a tick with counter = 2^W−1. The counter reloads from the current PRELOAD, not 0.
  - In one-shot mode, run[i] also clears on the same edge (RUN→IDLE).
  - If mask = 0, the overflow sets flag[i].
- A PRELOAD write while running takes effect only at the next reload. The current count is unaffected.
- Simultaneous set and clear of a flag (CTRL bit3 or GLOBAL bit7 in the same cycle as an overflow): set wins, so no event is lost.
- Changing mask does not change an existing flag.
- irq = OR of all flags. status is combinational from the flags.

## Timing
- Register writes are visible on the edge after reg_wr_valid.
- Start: the first tick occurs TICK_i cycles after run becomes 1.
- Overflow period = (2^W − PRELOAD) × TICK_i cycles. PRELOAD = 2^W−1 gives 1 tick per period.
- flag is set on the overflow edge. status reflects it in the same cycle. irq_n falls one clk later.
- A clear write drops the flag on the next edge. irq_n rises one cycle after that if no other flag is set.
- Reset (asynchronous, any time, including mid-count) sets:
  - PRELOAD, counters, prescalers, run, mask, one-shot and flags to 0.
  - status = 0, running = 0, irq_n = 1.

## Configuration
- OPL_TIMER_FORCE_OVF_EN defined:
  - Port force_overflow exists.
  - force_overflow[i]=1 sets flag[i] when unmasked, regardless of run state.
  - It does not touch the counter or the run state.
  - Used by trick-software detection.
- Not defined: the port is absent and the behaviour is identical to force_overflow tied to 0.

## Test plan
Bench settings: NUM_TIMERS=2, W=8, BASE_TICK_CYCLES=4, TICK_RATIO_LOG2=2.
- Auto-reload: PRELOAD[0]=0xFE, CTRL[0]=0x01 → flag0 sets 8 cycles after run, then every 8 cycles; irq_n=0 one cycle after the first flag; status=0x81.
- Channel 1 timing: PRELOAD[1]=0xFF, CTRL[1]=0x01 → flag1 sets 16 cycles after run; status=0x82.
- One-shot: CTRL[0]=0x05, PRELOAD[0]=0xFF → flag0 sets at 4 cycles and running[0]=0 on the same edge; no further overflow in 100 cycles.
- Masking and clear: CTRL[0]=0x03 → running[0]=1 and overflows occur but status stays 0x00; then GLOBAL=0x80 on the exact overflow cycle of an unmasked channel → the flag remains set.
- Stop/hold and reload: stop mid-count, then restart with CTRL=0x01 → counter holds while stopped; restart does not reload if still running; a PRELOAD write mid-run alters only the next period.
- Async reset mid-count: reset_n low for half a cycle → all outputs reach their reset values immediately; with OPL_TIMER_FORCE_OVF_EN, force_overflow=0b01 → flag0 sets with status=0x81 and running=0.

Source files
------------

// File: rtl/opl_timer_bank.sv
// -----------------------------------------------------------------------------
// opl_timer_bank
//
// Bank of OPL-style up-counting interval timers with a status byte and an
// active-low interrupt. Each channel has its own preload, tick prescaler,
// mask, one-shot mode and sticky overflow flag.
//
// Register map (byte writes on reg_wr_*):
//   2*i             PRELOAD[i]  reload value for channel i
//   2*i + 1         CTRL[i]     bit0 start, bit1 mask, bit2 one-shot,
//                               bit3 clear flag[i] (strobe, not stored)
//   2*NUM_TIMERS    GLOBAL      bit7 clears every flag
//   anything else is ignored.
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   reg_wr_valid    one-cycle register write strobe
//   reg_wr_addr     register address
//   reg_wr_data     register write data
//   status          bit7 = irq, bits[NUM_TIMERS-1:0] = flags, others 0
//   running         per-channel run state
//   irq_n           registered active-low interrupt (OR of all flags)
//   force_overflow  per-channel flag set request; exists only when the
//                   macro OPL_TIMER_FORCE_OVF_EN is defined
//
// Optional feature macro: OPL_TIMER_FORCE_OVF_EN. When undefined the port is
// absent and the bank behaves as if force_overflow were tied to zero.
// -----------------------------------------------------------------------------
module opl_timer_bank #(
  parameter int NUM_TIMERS       = 2,
  parameter int TIMER_WIDTH      = 8,
  parameter int BASE_TICK_CYCLES = 4000,
  parameter int TICK_RATIO_LOG2  = 2,
  parameter int ADDR_WIDTH       = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reg_wr_valid,
  input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [7:0]            reg_wr_data,
  output logic [7:0]            status,
  output logic [NUM_TIMERS-1:0] running,
  output logic                  irq_n
`ifdef OPL_TIMER_FORCE_OVF_EN
  ,
  input  logic [NUM_TIMERS-1:0] force_overflow
`endif
);

  // The slowest channel sets the prescaler width for every channel.
  localparam int MAX_TICK = BASE_TICK_CYCLES << ((NUM_TIMERS - 1) * TICK_RATIO_LOG2);
  localparam int PRE_W    = (MAX_TICK > 2) ? $clog2(MAX_TICK) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  logic [NUM_TIMERS-1:0] flag;
  logic [NUM_TIMERS-1:0] force_ovf;
  logic                  global_clr;
  logic                  irq_n_reg;

`ifdef OPL_TIMER_FORCE_OVF_EN
  assign force_ovf = force_overflow;
`else
  assign force_ovf = '0;
`endif

  assign global_clr = reg_wr_valid
                   && (reg_wr_addr == ADDR_WIDTH'(2 * NUM_TIMERS))
                   && reg_wr_data[7];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_chan
      localparam int              TICK_CYCLES = BASE_TICK_CYCLES << (gi * TICK_RATIO_LOG2);
      localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_CYCLES - 1);

      chan_state_t            state_reg, state_next;
      logic [TIMER_WIDTH-1:0] preload_reg, preload_next;
      logic [TIMER_WIDTH-1:0] counter_reg, counter_next;
      logic [PRE_W-1:0]       prescaler_reg, prescaler_next;
      logic                   mask_reg, mask_next;
      logic                   oneshot_reg, oneshot_next;
      logic                   flag_reg, flag_next;

      logic preload_wr;
      logic ctrl_wr;
      logic start_wr;
      logic stop_wr;
      logic tick;
      logic overflow;
      logic flag_set;
      logic flag_clr;

      assign preload_wr = reg_wr_valid && (reg_wr_addr == ADDR_WIDTH'(2 * gi));
      assign ctrl_wr    = reg_wr_valid && (reg_wr_addr == ADDR_WIDTH'(2 * gi + 1));

      // A start only acts from IDLE; re-writing start=1 while running keeps
      // the current count and prescaler phase.
      assign start_wr = ctrl_wr && reg_wr_data[0] && (state_reg == IDLE);
      assign stop_wr  = ctrl_wr && !reg_wr_data[0];

      // The stop edge itself produces no tick, even at the prescaler wrap.
      assign tick     = (state_reg == RUN) && !stop_wr && (prescaler_reg == PRE_LAST);
      assign overflow = tick && (counter_reg == '1);

      // Masking is judged on the mask in force before this edge.
      assign flag_set = (overflow || force_ovf[gi]) && !mask_reg;
      assign flag_clr = (ctrl_wr && reg_wr_data[3]) || global_clr;

      always_comb begin
        state_next     = state_reg;
        preload_next   = preload_reg;
        counter_next   = counter_reg;
        prescaler_next = prescaler_reg;
        mask_next      = mask_reg;
        oneshot_next   = oneshot_reg;
        flag_next      = flag_reg;

        // Counting path.
        if (start_wr) begin
          counter_next   = preload_reg;
          prescaler_next = '0;
        end else if (tick) begin
          prescaler_next = '0;
          // Reload uses the preload held before this edge, so a preload
          // written mid-period only shapes the following period.
          counter_next   = overflow ? preload_reg : counter_reg + TIMER_WIDTH'(1);
        end else if ((state_reg == RUN) && !stop_wr) begin
          prescaler_next = prescaler_reg + PRE_W'(1);
        end

        // Run state: one-shot expiry first, then explicit stop/start writes.
        if (overflow && oneshot_reg) begin
          state_next = IDLE;
        end
        if (stop_wr) begin
          state_next = IDLE;
        end else if (start_wr) begin
          state_next = RUN;
        end

        // Stored control bits.
        if (ctrl_wr) begin
          mask_next    = reg_wr_data[1];
          oneshot_next = reg_wr_data[2];
        end
        if (preload_wr) begin
          preload_next = reg_wr_data[TIMER_WIDTH-1:0];
        end

        // A set in the same cycle as a clear wins so no overflow is lost.
        if (flag_set) begin
          flag_next = 1'b1;
        end else if (flag_clr) begin
          flag_next = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_reg     <= IDLE;
          preload_reg   <= '0;
          counter_reg   <= '0;
          prescaler_reg <= '0;
          mask_reg      <= 1'b0;
          oneshot_reg   <= 1'b0;
          flag_reg      <= 1'b0;
        end else begin
          state_reg     <= state_next;
          preload_reg   <= preload_next;
          counter_reg   <= counter_next;
          prescaler_reg <= prescaler_next;
          mask_reg      <= mask_next;
          oneshot_reg   <= oneshot_next;
          flag_reg      <= flag_next;
        end
      end

      assign running[gi] = (state_reg == RUN);
      assign flag[gi]    = flag_reg;
    end
  endgenerate

  // status follows the flags combinationally; irq_n lags by one clock.
  always_comb begin
    status                 = '0;
    status[NUM_TIMERS-1:0] = flag;
    status[7]              = |flag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_n_reg <= 1'b1;
    end else begin
      irq_n_reg <= ~(|flag);
    end
  end

  assign irq_n = irq_n_reg;

endmodule

// File: tb/tb_opl_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_opl_timer_bank
//
// Directed and randomized bench for opl_timer_bank with NUM_TIMERS=2,
// TIMER_WIDTH=8, BASE_TICK_CYCLES=4, TICK_RATIO_LOG2=2. A behavioural model
// tracks, per channel, the cycles accumulated toward the next tick and the
// number of ticks remaining until overflow; outputs are compared every cycle.
// -----------------------------------------------------------------------------
module tb_opl_timer_bank;
  localparam int NT = 2;
  localparam int W  = 8;
  localparam int BT = 4;
  localparam int TR = 2;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          reg_wr_valid = 1'b0;
  logic [AW-1:0] reg_wr_addr = '0;
  logic [7:0]    reg_wr_data = '0;
  logic [7:0]    status;
  logic [NT-1:0] running;
  logic          irq_n;
  logic [NT-1:0] force_overflow = '0;

  always #5 clk = ~clk;

  opl_timer_bank #(
    .NUM_TIMERS      (NT),
    .TIMER_WIDTH     (W),
    .BASE_TICK_CYCLES(BT),
    .TICK_RATIO_LOG2 (TR),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .reg_wr_valid  (reg_wr_valid),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data),
    .status        (status),
    .running       (running),
    .irq_n         (irq_n)
`ifdef OPL_TIMER_FORCE_OVF_EN
    ,
    .force_overflow(force_overflow)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int m_run  [NT];
  int m_pre  [NT];
  int m_mask [NT];
  int m_os   [NT];
  int m_flag [NT];
  int m_acc  [NT];   // cycles counted since the last tick
  int m_left [NT];   // ticks still needed to reach overflow
  int m_ovfs [NT];   // overflow events seen by the model
  int m_irq_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_run[i] = 0; m_pre[i] = 0; m_mask[i] = 0; m_os[i] = 0;
      m_flag[i] = 0; m_acc[i] = 0; m_left[i] = 1 << W;
    end
    m_irq_n = 1;
  endtask

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < NT; i++) begin
      if (m_flag[i] != 0) begin
        s[i] = 1'b1;
        s[7] = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic [NT-1:0] exp_running();
    logic [NT-1:0] r;
    r = '0;
    for (int i = 0; i < NT; i++) r[i] = (m_run[i] != 0);
    return r;
  endfunction

  // Advance the model by one clock edge given the inputs present at that edge.
  task automatic model_edge(input logic v, input logic [AW-1:0] a, input logic [7:0] d,
                            input logic [NT-1:0] f);
    int  any_old;
    bit  glob_clr;
    any_old  = 0;
    for (int i = 0; i < NT; i++) if (m_flag[i] != 0) any_old = 1;
    glob_clr = v && (int'(a) == 2 * NT) && d[7];
    for (int i = 0; i < NT; i++) begin
      bit ctrl_wr, pre_wr, stop, start, ovf, set, clr;
      int tick_len;
      tick_len = BT << (i * TR);
      ctrl_wr  = v && (int'(a) == 2 * i + 1);
      pre_wr   = v && (int'(a) == 2 * i);
      stop     = ctrl_wr && !d[0];
      start    = ctrl_wr && d[0] && (m_run[i] == 0);
      ovf      = 0;
      if (start) begin
        m_acc[i]  = 0;
        m_left[i] = (1 << W) - m_pre[i];
      end else if ((m_run[i] != 0) && !stop) begin
        m_acc[i]++;
        if (m_acc[i] == tick_len) begin
          m_acc[i] = 0;
          m_left[i]--;
          if (m_left[i] == 0) begin
            ovf = 1;
            m_ovfs[i]++;
            m_left[i] = (1 << W) - m_pre[i];
          end
        end
      end
      set = (ovf || f[i]) && (m_mask[i] == 0);
      clr = (ctrl_wr && d[3]) || glob_clr;
      if (set) m_flag[i] = 1;
      else if (clr) m_flag[i] = 0;
      if (ovf && (m_os[i] != 0)) m_run[i] = 0;
      if (stop) m_run[i] = 0;
      if (start) m_run[i] = 1;
      if (ctrl_wr) begin
        m_mask[i] = int'(d[1]);
        m_os[i]   = int'(d[2]);
      end
      if (pre_wr) m_pre[i] = int'(d);
    end
    m_irq_n = any_old ? 0 : 1;
  endtask

  task automatic check_all();
    chk("status", 32'(status), 32'(exp_status()));
    chk("running", 32'(running), 32'(exp_running()));
    chk("irq_n", 32'(irq_n), 32'(m_irq_n));
  endtask

  task automatic step(input logic v, input logic [AW-1:0] a, input logic [7:0] d);
    logic [NT-1:0] f;
    reg_wr_valid = v;
    reg_wr_addr  = a;
    reg_wr_data  = d;
    f            = force_overflow;
    @(posedge clk);
    #1;
    model_edge(v, a, d, f);
    reg_wr_valid = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0);
  endtask

  task automatic wr(input int a, input int d);
    step(1'b1, AW'(a), 8'(d));
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        int         a;
        logic [7:0] d;
        a = $urandom_range(0, 8);
        if (a > 6) a = 31;
        d = 8'($urandom);
        if (a == 0 || a == 2) d[7:4] = 4'hF;
        if (a == 1 || a == 3) d[0] = ($urandom_range(0, 3) != 0);
        wr(a, int'(d));
      end else begin
        idle(1);
      end
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NT; i++) m_ovfs[i] = 0;

    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_status", 32'(status), 32'h00);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_irq_n", 32'(irq_n), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    // Auto-reload on channel 0: overflow 8 cycles after run, then every 8.
    wr(0, 8'hFE);
    wr(1, 8'h01);
    idle(7);
    chk("ar_before", 32'(status), 32'h00);
    idle(1);
    chk("ar_first", 32'(status), 32'h81);
    chk("ar_irq_lag", 32'(irq_n), 32'h1);
    idle(1);
    chk("ar_irq", 32'(irq_n), 32'h0);
    idle(20);
    wr(1, 8'h08);
    idle(2);
    chk("ar_cleared", 32'(status), 32'h00);
    chk("ar_irq_rise", 32'(irq_n), 32'h1);

    // Channel 1 timing: one tick of 16 cycles.
    wr(2, 8'hFF);
    wr(3, 8'h01);
    idle(15);
    chk("c1_before", 32'(status), 32'h00);
    idle(1);
    chk("c1_flag", 32'(status), 32'h82);
    wr(3, 8'h08);
    idle(2);

    // One-shot on channel 0.
    wr(0, 8'hFF);
    wr(1, 8'h05);
    idle(3);
    chk("os_running", 32'(running), 32'h1);
    idle(1);
    chk("os_flag", 32'(status), 32'h81);
    chk("os_stopped", 32'(running), 32'h0);
    idle(100);
    chk("os_no_more", 32'(m_run[0]), 32'h0);
    wr(4, 8'h80);
    idle(2);
    chk("os_gclr", 32'(status), 32'h00);

    // Masked channel runs but never flags.
    wr(1, 8'h03);
    idle(20);
    chk("mask_status", 32'(status), 32'h00);
    chk("mask_running", 32'(running), 32'h1);
    wr(1, 8'h00);

    // Clear coinciding with an overflow on channel 1: set wins.
    wr(2, 8'hFF);
    wr(3, 8'h01);
    idle(15);
    wr(4, 8'h80);
    chk("gclr_race", 32'(status), 32'h82);
    idle(15);
    wr(3, 8'h09);
    chk("cclr_race", 32'(status), 32'h82);
    wr(3, 8'h08);
    idle(2);

    // Stop/hold, restart, no restart while running, preload for next period.
    wr(0, 8'hFC);
    wr(1, 8'h01);
    idle(6);
    wr(1, 8'h00);
    idle(30);
    chk("hold_running", 32'(running), 32'h0);
    wr(1, 8'h01);
    idle(5);
    wr(1, 8'h01);
    wr(0, 8'hFE);
    idle(8);
    chk("rl_before", 32'(status), 32'h00);
    idle(1);
    chk("rl_first", 32'(status), 32'h81);
    wr(1, 8'h09);
    idle(6);
    chk("rl_short_before", 32'(status), 32'h00);
    idle(1);
    chk("rl_short", 32'(status), 32'h81);
    wr(1, 8'h08);
    idle(2);

    // Randomized traffic against the model.
    random_phase(2500);

    // Asynchronous reset in the middle of a count.
    wr(0, 8'hFE);
    wr(1, 8'h01);
    wr(2, 8'hF8);
    wr(3, 8'h01);
    idle(9);
    reset_n = 1'b0;
    #1;
    chk("arst_status", 32'(status), 32'h00);
    chk("arst_running", 32'(running), 32'h0);
    chk("arst_irq_n", 32'(irq_n), 32'h1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(40);
    chk("arst_after", 32'(status), 32'h00);

`ifdef OPL_TIMER_FORCE_OVF_EN
    force_overflow = 2'b01;
    idle(1);
    force_overflow = 2'b00;
    chk("force_status", 32'(status), 32'h81);
    chk("force_running", 32'(running), 32'h0);
    wr(4, 8'h80);
    idle(2);
`endif

    random_phase(1500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
